// File: rtl/demux1x4_reg.sv
// demux1x4_reg: registered 1:4 demultiplexor with valid/ready handshaking.
// One producer feeds four independently stalling consumers. Each output port
// owns a single-entry register, so a stalled consumer only blocks words that
// are headed for its own port.
module demux1x4_reg #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in_data,
  input  logic [1:0]      in_port,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out_data [4],
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready
);

  logic [SIZE-1:0] r_data [4];
  logic [3:0]      r_full;

  logic            w_acc;
  logic [3:0]      w_write;
  logic [3:0]      w_drain;

  // Handshake decode: the target port can take a word if it is empty or is
  // being emptied this cycle; ready deliberately ignores in_valid.
  always_comb begin
    in_ready = 1'b0;
    w_acc    = 1'b0;
    w_write  = 4'b0000;
    w_drain  = 4'b0000;

    in_ready = ~r_full[in_port] | out_ready[in_port];
    w_acc    = in_valid & in_ready;
    if (w_acc) begin
      w_write[in_port] = 1'b1;
    end
    w_drain  = r_full & out_ready;
  end

  // Occupancy flags: an accept wins over a drain on the same port, so a
  // simultaneous accept+drain leaves the port full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_write[i]) begin
          r_full[i] <= 1'b1;
        end else if (w_drain[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Entry registers: a port's word only changes when a new word is accepted
  // for that port; a drain leaves the stale value in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_write[i]) begin
          r_data[i] <= in_data;
        end
      end
    end
  end

  // Output view: each port exposes its held word and its occupancy flag.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_data[i] = r_data[i];
    end
    out_valid = r_full;
  end

endmodule

// File: tb/tb_demux1x4_reg.sv
// tb_demux1x4_reg: directed and scoreboard-checked bench for demux1x4_reg.
module tb_demux1x4_reg;

  localparam int SIZE = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SIZE-1:0] in_data;
  logic [1:0]      in_port;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] out_data [4];
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;

  int total = 0;
  int bad   = 0;

  demux1x4_reg #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_port   (in_port),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs and let the combinational ready settle.
  task automatic applyStimulus(input logic v, input logic [1:0] p, input logic [SIZE-1:0] d, input logic [3:0] r);
    in_valid  = v;
    in_port   = p;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Advance one rising edge and move clear of it before sampling.
  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  logic [SIZE-1:0] steerData [4];
  logic [SIZE-1:0] sbData [4];
  bit              sbFull [4];
  int              acceptedCount;
  int              deliveredCount;

  initial begin
    logic            holdOffer;
    logic            rv;
    logic [1:0]      rp;
    logic [SIZE-1:0] rd;
    logic            expReady;

    steerData[0] = 3'b001;
    steerData[1] = 3'b100;
    steerData[2] = 3'b111;
    steerData[3] = 3'b010;

    // Reset state, with a word offered during reset that must be discarded.
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'd2, 3'b101, 4'b0000);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    for (int p = 0; p < 4; p++) checkOutput("rst_data", 32'(out_data[p]), 32'h0);
    checkOutput("rst_ready", 32'(in_ready), 32'h1);
    stepCycle();
    checkOutput("rst_discard", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 3'b000, 4'b0000);

    // Basic steer to all four ports with every consumer stalled.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'(k), steerData[k], 4'b0000);
      checkOutput("steer_ready", 32'(in_ready), 32'h1);
      stepCycle();
    end
    applyStimulus(1'b0, 2'd0, 3'b000, 4'b0000);
    checkOutput("steer_valid", 32'(out_valid), 32'hF);
    checkOutput("steer_d0", 32'(out_data[0]), 32'h1);
    checkOutput("steer_d1", 32'(out_data[1]), 32'h4);
    checkOutput("steer_d2", 32'(out_data[2]), 32'h7);
    checkOutput("steer_d3", 32'(out_data[3]), 32'h2);
    for (int p = 0; p < 4; p++) begin
      applyStimulus(1'b1, 2'(p), 3'b000, 4'b0000);
      checkOutput("full_notready", 32'(in_ready), 32'h0);
    end

    // Stall isolation: drain port 3, then port 1 stays blocked while port 3 accepts.
    applyStimulus(1'b0, 2'd0, 3'b000, 4'b1000);
    stepCycle();
    checkOutput("drain3_valid", 32'(out_valid), 32'h7);
    applyStimulus(1'b1, 2'd1, 3'b101, 4'b0000);
    checkOutput("stall1_ready", 32'(in_ready), 32'h0);
    stepCycle();
    checkOutput("stall1_hold", 32'(out_data[1]), 32'h4);
    checkOutput("stall1_valid", 32'(out_valid), 32'h7);
    applyStimulus(1'b1, 2'd3, 3'b110, 4'b0000);
    checkOutput("iso3_ready", 32'(in_ready), 32'h1);
    stepCycle();
    checkOutput("iso3_valid", 32'(out_valid), 32'hF);
    checkOutput("iso3_data", 32'(out_data[3]), 32'h6);
    checkOutput("iso1_data", 32'(out_data[1]), 32'h4);

    // Simultaneous accept and drain on port 2.
    applyStimulus(1'b1, 2'd2, 3'b011, 4'b0100);
    checkOutput("ad2_ready", 32'(in_ready), 32'h1);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 3'b000, 4'b0000);
    checkOutput("ad2_valid", 32'(out_valid), 32'hF);
    checkOutput("ad2_data", 32'(out_data[2]), 32'h3);

    // Asynchronous reset mid-operation clears state before any edge.
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid", 32'(out_valid), 32'h0);
    checkOutput("mrst_data2", 32'(out_data[2]), 32'h0);
    checkOutput("mrst_ready", 32'(in_ready), 32'h1);
    #1;
    rst_n = 1'b1;
    stepCycle();

    // Streaming eight words to port 0 with its consumer always ready.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 2'd0, 3'(k), 4'b0001);
      checkOutput("stream_ready", 32'(in_ready), 32'h1);
      if (k == 0) begin
        checkOutput("stream_v0", 32'(out_valid[0]), 32'h0);
      end else begin
        checkOutput("stream_valid", 32'(out_valid[0]), 32'h1);
        checkOutput("stream_data", 32'(out_data[0]), 32'(k - 1));
      end
      stepCycle();
    end
    applyStimulus(1'b0, 2'd0, 3'b000, 4'b0001);
    checkOutput("stream_last_v", 32'(out_valid[0]), 32'h1);
    checkOutput("stream_last_d", 32'(out_data[0]), 32'h7);
    stepCycle();
    checkOutput("stream_empty", 32'(out_valid), 32'h0);

    // Random traffic against a single-entry-per-port scoreboard.
    for (int i = 0; i < 4; i++) begin
      sbFull[i] = 1'b0;
      sbData[i] = '0;
    end
    acceptedCount  = 0;
    deliveredCount = 0;
    holdOffer      = 1'b0;
    rv = 1'b0;
    rp = 2'd0;
    rd = '0;
    for (int c = 0; c < 1000; c++) begin
      if (!holdOffer) begin
        rv = ($urandom_range(0, 9) < 7);
        rp = 2'($urandom_range(0, 3));
        rd = 3'($urandom_range(0, 7));
      end
      applyStimulus(rv, rp, rd, 4'($urandom_range(0, 15)));
      expReady = !sbFull[rp] || out_ready[rp];
      checkOutput("rand_ready", 32'(in_ready), 32'(expReady));
      for (int i = 0; i < 4; i++) begin
        checkOutput("rand_valid", 32'(out_valid[i]), 32'(sbFull[i]));
        if (sbFull[i] && out_ready[i]) begin
          checkOutput("rand_data", 32'(out_data[i]), 32'(sbData[i]));
          deliveredCount++;
          sbFull[i] = 1'b0;
        end
      end
      if (rv && expReady) begin
        sbFull[rp] = 1'b1;
        sbData[rp] = rd;
        acceptedCount++;
      end
      holdOffer = rv && !expReady;
      stepCycle();
    end

    // Drain whatever is left and confirm every accepted word came out once.
    applyStimulus(1'b0, 2'd0, 3'b000, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      checkOutput("final_valid", 32'(out_valid[i]), 32'(sbFull[i]));
      if (sbFull[i]) begin
        checkOutput("final_data", 32'(out_data[i]), 32'(sbData[i]));
        deliveredCount++;
        sbFull[i] = 1'b0;
      end
    end
    stepCycle();
    checkOutput("final_empty", 32'(out_valid), 32'h0);
    checkOutput("exactly_once", 32'(deliveredCount), 32'(acceptedCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
